rgb_led_sequencer: RTL and testbench

//  Downstream consumer of the board's blink/tick counter stage. Takes its one-cycle

---
 rtl/rgb_led_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rgb_led_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer
// Drives the on-board RGB LED from the blink counter's tick pulse. The colour
// steps RED -> GREEN -> BLUE -> RED, either at full brightness (solid) or with a
// PWM triangle ramp (breathe). The PWM duty is double-buffered: duty_next is
// updated by the sequencer and copied into duty_act only when the PWM counter
// wraps, so a running PWM period never sees a duty change.

module rgb_led_sequencer #(
    parameter int PWM_BITS = 4,   // PWM counter / duty width, period 2^PWM_BITS
    parameter int STEP     = 4,   // breathe duty step per tick
    parameter int DUTY_MAX = 15   // peak duty, also the solid-mode duty
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       redled,
    output logic       greenled,
    output logic       blueled
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // Duty constants in both the register width and the one-bit-wider
    // arithmetic width used for the ramp comparisons.
    localparam logic [PWM_BITS-1:0] DUTY_PEAK = DUTY_MAX[PWM_BITS-1:0];
    localparam logic [PWM_BITS:0]   PEAK_W    = DUTY_MAX[PWM_BITS:0];
    localparam logic [PWM_BITS:0]   STEP_W    = STEP[PWM_BITS:0];

    state_t              state, state_nx;
    dir_t                dir, dir_nx;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_next, duty_next_nx;
    logic [PWM_BITS-1:0] duty_act;
    logic                breathe_q, breathe_nx;   // mode latched at RED entry

    logic                mode_solid;
    logic                mode_breathe;
    logic                active_req;
    logic                pwm_wrap;
    logic [PWM_BITS-1:0] entry_duty;
    logic [PWM_BITS:0]   sum_up;

    assign mode_solid   = (mode == 2'b01);
    assign mode_breathe = (mode == 2'b10);
    assign active_req   = enable & (mode_solid | mode_breathe);
    assign pwm_wrap     = (pwm_cnt == {PWM_BITS{1'b1}});
    assign entry_duty   = mode_breathe ? '0 : DUTY_PEAK;
    assign sum_up       = {1'b0, duty_next} + STEP_W;

    function automatic state_t next_colour(input state_t s);
        case (s)
            RED:     return GREEN;
            GREEN:   return BLUE;
            BLUE:    return RED;
            default: return RED;
        endcase
    endfunction

    // Next-state logic: idle/entry/restart take priority over tick stepping.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_nx     = state;
        dir_nx       = dir;
        duty_next_nx = duty_next;
        breathe_nx   = breathe_q;

        if (!active_req) begin
            state_nx     = IDLE;
            duty_next_nx = '0;
            dir_nx       = UP;
            breathe_nx   = 1'b0;
        end else if (state == IDLE || breathe_q != mode_breathe) begin
            // Fresh entry or a solid<->breathe switch: restart at RED and drop
            // any tick arriving in the same cycle.
            state_nx     = RED;
            duty_next_nx = entry_duty;
            dir_nx       = UP;
            breathe_nx   = mode_breathe;
        end else if (tick) begin
            if (!breathe_q) begin
                state_nx     = next_colour(state);
                duty_next_nx = DUTY_PEAK;
            end else if (dir == UP) begin
                if (sum_up >= PEAK_W) begin
                    duty_next_nx = DUTY_PEAK;
                    dir_nx       = DOWN;
                end else begin
                    duty_next_nx = sum_up[PWM_BITS-1:0];
                end
            end else begin
                // Comparison is done wide so the decrement can never wrap.
                if ({1'b0, duty_next} <= STEP_W) begin
                    duty_next_nx = '0;
                    dir_nx       = UP;
                    state_nx     = next_colour(state);
                end else begin
                    duty_next_nx = duty_next - STEP_W[PWM_BITS-1:0];
                end
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            dir       <= UP;
            duty_next <= '0;
            breathe_q <= 1'b0;
        end else begin
            state     <= state_nx;
            dir       <= dir_nx;
            duty_next <= duty_next_nx;
            breathe_q <= breathe_nx;
        end
    end

    // Free-running PWM counter, wraps naturally at 2^PWM_BITS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Shadow duty: load only as the counter wraps to 0, at a period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act <= '0;
        end else if (pwm_wrap) begin
            duty_act <= duty_next;
        end
    end

    // Registered LED drive; gated by active_req so a disable blanks the LEDs
    // on the very next edge rather than one edge after the state update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redled   <= 1'b0;
            greenled <= 1'b0;
            blueled  <= 1'b0;
        end else begin
            redled   <= active_req && (state == RED)   && (pwm_cnt < duty_act);
            greenled <= active_req && (state == GREEN) && (pwm_cnt < duty_act);
            blueled  <= active_req && (state == BLUE)  && (pwm_cnt < duty_act);
        end
    end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Directed testbench for rgb_led_sequencer (PWM_BITS=4, STEP=4, DUTY_MAX=15).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_rgb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       redled, greenled, blueled;

    int assertions = 0;
    int failures   = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RED   = 2'd1;
    localparam logic [1:0] S_GREEN = 2'd2;
    localparam logic [1:0] S_BLUE  = 2'd3;

    rgb_led_sequencer #(
        .PWM_BITS (4),
        .STEP     (4),
        .DUTY_MAX (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .enable   (enable),
        .mode     (mode),
        .redled   (redled),
        .greenled (greenled),
        .blueled  (blueled)
    );

    always #5 clk = ~clk;

    // Single-cycle tick, issued and finished on falling edges.
    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Skip past any period whose duty was loaded before the latest change.
    task automatic sync_period();
        bit found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dut.pwm_cnt == 4'd2) begin
                found = 1'b1;
                break;
            end
        end
        assertions++;
        if (!found) begin
            failures++;
            $display("FAIL sync_timeout: pwm_cnt never reached 2");
        end
    endtask

    // Count LED on-cycles over one full PWM period (pwm values 0..15 at the
    // register input). Optionally pulses tick when pwm_cnt equals tick_at.
    task automatic measure(input int tick_at, output int r, output int g,
                           output int b, output bit multi);
        bit found = 1'b0;
        r = 0; g = 0; b = 0; multi = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (dut.pwm_cnt == 4'd1) begin
                found = 1'b1;
                break;
            end
        end
        assertions++;
        if (!found) begin
            failures++;
            $display("FAIL measure_timeout: pwm_cnt never reached 1");
        end
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            r += int'(redled);
            g += int'(greenled);
            b += int'(blueled);
            if (int'(redled) + int'(greenled) + int'(blueled) > 1) multi = 1'b1;
            tick = (tick_at >= 0 && int'(dut.pwm_cnt) == tick_at);
        end
        tick = 1'b0;
    endtask

    task automatic check_counts(input string name, input int er, input int eg,
                                input int eb);
        int r, g, b;
        bit multi;
        sync_period();
        measure(-1, r, g, b, multi);
        assertions++;
        if (r !== er || g !== eg || b !== eb) begin
            failures++;
            $display("FAIL %s: on-counts r/g/b got %0d/%0d/%0d expected %0d/%0d/%0d",
                     name, r, g, b, er, eg, eb);
        end
        assertions++;
        if (multi !== 1'b0) begin
            failures++;
            $display("FAIL %s_onehot: more than one LED on, got 1 expected 0", name);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] exp);
        assertions++;
        if (dut.state !== exp) begin
            failures++;
            $display("FAIL %s: state got %0d expected %0d", name, dut.state, exp);
        end
    endtask

    task automatic check_duty(input string name, input logic [3:0] exp_duty,
                              input logic exp_dir);
        assertions++;
        if (dut.duty_next !== exp_duty || dut.dir !== exp_dir) begin
            failures++;
            $display("FAIL %s: duty_next/dir got %0d/%0d expected %0d/%0d",
                     name, dut.duty_next, dut.dir, exp_duty, exp_dir);
        end
    endtask

    task automatic check_leds_off(input string name);
        assertions++;
        if ({redled, greenled, blueled} !== 3'b000) begin
            failures++;
            $display("FAIL %s: leds rgb got %b expected 000", name,
                     {redled, greenled, blueled});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; mode = 2'b00; tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start(input logic [1:0] m);
        enable = 1'b1;
        mode   = m;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; mode = 2'b00; tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_leds_off("reset_leds");
        check_state("reset_state", S_IDLE);
        check_duty("reset_duty", 4'd0, 1'b0);
        assertions++;
        if (dut.duty_act !== 4'd0 || dut.pwm_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_pwm: duty_act/pwm_cnt got %0d/%0d expected 0/0",
                     dut.duty_act, dut.pwm_cnt);
        end
        rst = 1'b0;
        // mode 11 behaves as off, as does enable=0 with a valid mode
        enable = 1'b1; mode = 2'b11;
        repeat (3) @(negedge clk);
        check_state("mode11_idle", S_IDLE);
        check_leds_off("mode11_leds");
        enable = 1'b0; mode = 2'b01;
        pulse_tick();
        @(negedge clk);
        check_state("disabled_idle", S_IDLE);
    endtask

    task automatic test_solid();
        do_reset();
        start(2'b01);
        check_state("solid_entry", S_RED);
        check_duty("solid_entry_duty", 4'd15, 1'b0);
        check_counts("solid_red", 15, 0, 0);
        pulse_tick();
        check_counts("solid_green", 0, 15, 0);
        pulse_tick();
        check_counts("solid_blue", 0, 0, 15);
        pulse_tick();
        check_counts("solid_red_again", 15, 0, 0);
    endtask

    task automatic test_breathe();
        logic [3:0] exp_duty [8] = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd11, 4'd7, 4'd3, 4'd0};
        logic       exp_dir  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        start(2'b10);
        check_duty("breathe_entry", 4'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            pulse_tick();
            check_duty($sformatf("breathe_step%0d", k + 1), exp_duty[k], exp_dir[k]);
            if (k < 7) check_counts($sformatf("breathe_count%0d", k + 1),
                                    int'(exp_duty[k]), 0, 0);
        end
        check_state("breathe_green", S_GREEN);
        check_counts("breathe_green_dark", 0, 0, 0);
        pulse_tick();
        check_duty("breathe_green_rise", 4'd4, 1'b0);
        check_counts("breathe_green_on", 0, 4, 0);
    endtask

    task automatic test_shadow();
        int r, g, b;
        bit multi;
        do_reset();
        start(2'b10);
        pulse_tick();
        check_duty("shadow_pre", 4'd4, 1'b0);
        sync_period();
        measure(5, r, g, b, multi);
        check_duty("shadow_next", 4'd8, 1'b0);
        assertions++;
        if (r !== 4) begin
            failures++;
            $display("FAIL shadow_same_period: red on-count got %0d expected 4", r);
        end
        measure(-1, r, g, b, multi);
        assertions++;
        if (r !== 8) begin
            failures++;
            $display("FAIL shadow_next_period: red on-count got %0d expected 8", r);
        end
    endtask

    task automatic test_enable_drop();
        bit found = 1'b0;
        do_reset();
        start(2'b01);
        pulse_tick();
        sync_period();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (greenled === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        assertions++;
        if (!found) begin
            failures++;
            $display("FAIL drop_green_on: greenled got 0 expected 1");
        end
        enable = 1'b0;
        @(negedge clk);
        check_leds_off("drop_leds");
        check_state("drop_idle", S_IDLE);
        check_duty("drop_duty", 4'd0, 1'b0);
        start(2'b10);
        check_state("reenable_red", S_RED);
        check_duty("reenable_duty", 4'd0, 1'b0);
        pulse_tick();
        check_duty("reenable_rise", 4'd4, 1'b0);
    endtask

    task automatic test_collision();
        do_reset();
        start(2'b01);
        pulse_tick();
        pulse_tick();
        check_state("collision_pre", S_BLUE);
        mode = 2'b10;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check_state("collision_red", S_RED);
        check_duty("collision_duty", 4'd0, 1'b0);
        pulse_tick();
        check_duty("collision_after", 4'd4, 1'b0);
        // and back from breathe to solid
        mode = 2'b01;
        @(negedge clk);
        check_state("collision_back_red", S_RED);
        check_duty("collision_back_duty", 4'd15, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        start(2'b01);
        tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
        check_state("b2b_solid", S_BLUE);
        do_reset();
        start(2'b10);
        tick = 1'b1;
        repeat (5) @(negedge clk);
        tick = 1'b0;
        check_duty("b2b_breathe", 4'd11, 1'b1);
        check_state("b2b_breathe_state", S_RED);
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        do_reset();
        start(2'b10);
        repeat (3) pulse_tick();
        sync_period();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (redled === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        assertions++;
        if (!found) begin
            failures++;
            $display("FAIL midreset_red_on: redled got 0 expected 1");
        end
        #2 rst = 1'b1;
        #1;
        check_leds_off("midreset_async");
        check_state("midreset_state", S_IDLE);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("midreset_release", S_IDLE);
        assertions++;
        if (dut.duty_act !== 4'd0) begin
            failures++;
            $display("FAIL midreset_duty_act: got %0d expected 0", dut.duty_act);
        end
        @(negedge clk);
        check_state("midreset_reentry", S_RED);
        check_duty("midreset_reentry_duty", 4'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_solid();
        test_breathe();
        test_shadow();
        test_enable_drop();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
